// File: rtl/imem_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_if
// Description : Fetch request/response, flush, loader and status bundle
//               between the PC/fetch stage and the instruction memory.
//               The rsp_fault member exists only when IMEM_BOUNDS_CHECK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_if #(
  parameter int IMW = 4,
  parameter int IW  = 32,
  parameter int AW  = 32
);
  // Fetch request channel
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_pc;
  // Fetch response channel
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_instr;
  logic [AW-1:0]  rsp_pc;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic           rsp_fault;
`endif
  // Redirect and boot-loader write port
  logic           flush;
  logic           load_en;
  logic [IMW-1:0] load_addr;
  logic [IW-1:0]  load_data;
  // Status
  logic           busy;

  // Fetch stage / loader side
  modport master (
    output req_valid, req_pc, rsp_ready, flush, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, busy
`ifdef IMEM_BOUNDS_CHECK_EN
    , input rsp_fault
`endif
  );

  // Instruction memory side
  modport slave (
    input  req_valid, req_pc, rsp_ready, flush, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, busy
`ifdef IMEM_BOUNDS_CHECK_EN
    , output rsp_fault
`endif
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch
// Description : Synchronous-read instruction memory with valid/ready fetch,
//               post-reset NOP-fill sweep, boot-loader write port, response
//               back-pressure and flush. Optional macro IMEM_BOUNDS_CHECK_EN
//               adds rsp_fault for misaligned / out-of-range PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch #(
  parameter int            IMW       = 4,
  parameter int            IW        = 32,
  parameter int            AW        = 32,
  parameter logic [IW-1:0] NOP_INSTR = IW'(32'h0000_0013)
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_fetch_if.slave bus
);

  localparam int DEPTH = 1 << IMW;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IMW-1:0] cnt_q, cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]  rsp_pc_q, rsp_pc_d;
  // Forces rsp_instr to NOP_INSTR (reset value, faulting fetch) so the
  // memory read register itself never needs a reset.
  logic           nop_sel_q, nop_sel_d;

  logic           req_ready_w;
  logic           accept_w;
  logic           fault_w;
  logic [IMW-1:0] rd_idx_w;

  logic           mem_we_w;
  logic           mem_re_w;
  logic [IMW-1:0] mem_addr_w;
  logic [IW-1:0]  mem_wdata_w;
  logic [IW-1:0]  mem_q [DEPTH];
  logic [IW-1:0]  rd_data_q;

  // Word index of the requested PC (byte offset dropped, upper bits ignored)
  assign rd_idx_w = bus.req_pc[IMW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic upper_nz_w;
  logic fault_q, fault_d;

  if (AW > IMW + 2) begin : g_upper_chk
    assign upper_nz_w = |bus.req_pc[AW-1:IMW+2];
  end else begin : g_no_upper_chk
    assign upper_nz_w = 1'b0;
  end

  assign fault_w       = (bus.req_pc[1:0] != 2'b00) || upper_nz_w;
  assign bus.rsp_fault = fault_q;
`else
  // Byte offset and upper PC bits deliberately ignored: address wraps
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.req_pc[1:0], bus.req_pc[AW-1:IMW+2]};
  assign fault_w        = 1'b0;
`endif

  // A request is taken only in RUN, when neither the loader nor a redirect
  // owns this cycle, and the response register is free or being drained.
  assign req_ready_w = (state_q == ST_RUN) && !bus.load_en && !bus.flush &&
                       (!rsp_valid_q || bus.rsp_ready);
  assign accept_w    = bus.req_valid && req_ready_w;

  // Single memory port: sweep write, loader write or fetch read. The ready
  // gating above guarantees a read never coincides with a write.
  always_comb begin
    mem_we_w    = 1'b0;
    mem_re_w    = 1'b0;
    mem_addr_w  = rd_idx_w;
    mem_wdata_w = NOP_INSTR;
    if (state_q == ST_INIT) begin
      mem_we_w    = 1'b1;
      mem_addr_w  = cnt_q;
      mem_wdata_w = NOP_INSTR;
    end else if (bus.load_en) begin
      mem_we_w    = 1'b1;
      mem_addr_w  = bus.load_addr;
      mem_wdata_w = bus.load_data;
    end else if (accept_w && !fault_w) begin
      mem_re_w    = 1'b1;
      mem_addr_w  = rd_idx_w;
    end
  end

  // Memory array and synchronous read register (no reset: RAM inference)
  always_ff @(posedge clk) begin
    if (mem_we_w) begin
      mem_q[mem_addr_w] <= mem_wdata_w;
    end
    if (mem_re_w) begin
      rd_data_q <= mem_q[mem_addr_w];
    end
  end

  // Next state: INIT sweeps every word once, then RUN forever
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Response register next values: flush wins, then accept, then drain
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    nop_sel_d   = nop_sel_q;
    if (bus.flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept_w) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = bus.req_pc;
      nop_sel_d   = fault_w;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response state registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      nop_sel_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      nop_sel_q   <= nop_sel_d;
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  // Fault flag follows the same hold/flush behaviour as the instruction
  always_comb begin
    fault_d = fault_q;
    if (!bus.flush && accept_w) begin
      fault_d = fault_w;
    end
  end

  // Fault flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_pc    = rsp_pc_q;
  assign bus.rsp_instr = nop_sel_q ? NOP_INSTR : rd_data_q;
  assign bus.busy      = (state_q == ST_INIT);

endmodule
`default_nettype wire
